// File: rtl/pc_reg_pkg.sv
// Shared definitions for the program-counter stage: bus widths,
// ROM port-owner encodings and the default reset/flush fetch addresses.
package pc_reg_pkg;

   localparam int unsigned PC_ADDR_W   = 32;
   localparam int unsigned PC_DATA_W   = 32;
   localparam logic [31:0] PC_RESET_PC = 32'h0000_0000;
   localparam logic [31:0] PC_FLUSH_PC = 32'h0000_0000;

   // 2'b11 is not a named owner and behaves as an instruction fetch.
   typedef enum logic [1:0] {
      PC_ROM_OP_INST  = 2'b00,
      PC_ROM_OP_READ  = 2'b01,
      PC_ROM_OP_WRITE = 2'b10
   } pc_rom_op_e;

   function automatic logic is_data_op(input logic [1:0] op);
      return (op == PC_ROM_OP_READ) || (op == PC_ROM_OP_WRITE);
   endfunction

endpackage

// File: rtl/pc_reg.sv
// pc_reg: fetch PC and fetch enable for the 5-stage pipeline, with a shared ROM port.
// Define PC_ROM_SHARE_EN to let the MEM stage read/write ROM data through this port.
module pc_reg
   import pc_reg_pkg::*;
#(
   parameter int unsigned       ADDR_W   = PC_ADDR_W,
   parameter int unsigned       DATA_W   = PC_DATA_W,
   parameter logic [ADDR_W-1:0] RESET_PC = ADDR_W'(PC_RESET_PC),
   parameter logic [ADDR_W-1:0] FLUSH_PC = ADDR_W'(PC_FLUSH_PC)
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              flush,
   input  logic [5:0]        stall,
   input  logic              branch_flag_i,
   input  logic [ADDR_W-1:0] branch_target_address_i,
   input  logic [1:0]        rom_op_i,
   input  logic [DATA_W-1:0] rom_wr_data_i,
   input  logic [ADDR_W-1:0] rom_rw_addr_i,
   output logic [ADDR_W-1:0] pc_or_addr,
   output logic              ce,
   output logic              rom_op_o,
   output logic [DATA_W-1:0] wr_data_o
);

   logic              r_ce;
   logic [ADDR_W-1:0] r_pc;
   logic [ADDR_W-1:0] w_pc_next;
   logic              w_data_hold;
   logic              w_unused;

`ifdef PC_ROM_SHARE_EN
   assign w_data_hold = is_data_op(rom_op_i);
   assign w_unused    = ^stall[5:1];
`else
   assign w_data_hold = 1'b0;
   assign w_unused    = ^{stall[5:1], rom_op_i, rom_rw_addr_i, rom_wr_data_i};
`endif

   // A branch that coincides with a stall or data access is dropped; ID re-issues it.
   always_comb begin
      // NOTE: default first so every path assigns w_pc_next and no latch is inferred.
      w_pc_next = r_pc + ADDR_W'(4);
      if (!r_ce)
         w_pc_next = RESET_PC;
      else if (flush)
         w_pc_next = FLUSH_PC;
      else if (stall[0] || w_data_hold)
         w_pc_next = r_pc;
      else if (branch_flag_i)
         w_pc_next = branch_target_address_i;
   end

   always_ff @(posedge clk) begin
      // NOTE: non-blocking assignments so every register samples pre-edge values.
      if (rst) begin
         r_ce <= 1'b0;
         r_pc <= RESET_PC;
      end else begin
         r_ce <= 1'b1;
         r_pc <= w_pc_next;
      end
   end

   assign ce = r_ce;

   always_comb begin
      pc_or_addr = r_pc;
      rom_op_o   = 1'b0;
      wr_data_o  = '0;
      if (!r_ce) begin
         pc_or_addr = '0;
      end else begin
`ifdef PC_ROM_SHARE_EN
         case (rom_op_i)
            PC_ROM_OP_READ:  pc_or_addr = rom_rw_addr_i;
            PC_ROM_OP_WRITE: begin
               pc_or_addr = rom_rw_addr_i;
               rom_op_o   = 1'b1;
               wr_data_o  = rom_wr_data_i;
            end
            default: ;
         endcase
`endif
      end
   end

endmodule

// File: tb/tb_pc_reg.sv
// Scoreboard bench for pc_reg: directed scenarios followed by random traffic,
// expected port values come from a behavioural model of the fetch-PC rules.
module tb_pc_reg;
   import pc_reg_pkg::*;

   localparam int unsigned AW = PC_ADDR_W;
   localparam int unsigned DW = PC_DATA_W;
`ifdef PC_ROM_SHARE_EN
   localparam bit SHARE = 1'b1;
`else
   localparam bit SHARE = 1'b0;
`endif

   logic          clk = 1'b0;
   logic          rst = 1'b1;
   logic          flush = 1'b0;
   logic [5:0]    stall = '0;
   logic          branch_flag_i = 1'b0;
   logic [AW-1:0] branch_target_address_i = '0;
   logic [1:0]    rom_op_i = '0;
   logic [DW-1:0] rom_wr_data_i = '0;
   logic [AW-1:0] rom_rw_addr_i = '0;
   logic [AW-1:0] pc_or_addr;
   logic          ce;
   logic          rom_op_o;
   logic [DW-1:0] wr_data_o;

   pc_reg dut (
      .clk                     (clk),
      .rst                     (rst),
      .flush                   (flush),
      .stall                   (stall),
      .branch_flag_i           (branch_flag_i),
      .branch_target_address_i (branch_target_address_i),
      .rom_op_i                (rom_op_i),
      .rom_wr_data_i           (rom_wr_data_i),
      .rom_rw_addr_i           (rom_rw_addr_i),
      .pc_or_addr              (pc_or_addr),
      .ce                      (ce),
      .rom_op_o                (rom_op_o),
      .wr_data_o               (wr_data_o)
   );

   always #10 clk = ~clk;

   typedef struct packed {
      logic          ce;
      logic [AW-1:0] addr;
      logic          op;
      logic [DW-1:0] wdata;
   } obs_t;

   obs_t exp_q[$];
   int   n_checks = 0;
   int   n_pass   = 0;

   // Model state: the fetch address the pipeline believes it holds.
   bit            m_known = 1'b0;
   bit            m_ce;
   logic [AW-1:0] m_pc;

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_checks++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
   endtask

   always @(negedge clk) begin : monitor
      obs_t e;
      if (exp_q.size() != 0) begin
         e = exp_q.pop_front();
         check("ce",         64'(ce),         64'(e.ce));
         check("pc_or_addr", 64'(pc_or_addr), 64'(e.addr));
         check("rom_op_o",   64'(rom_op_o),   64'(e.op));
         check("wr_data_o",  64'(wr_data_o),  64'(e.wdata));
      end
   end

   task automatic step(input bit r, input bit f, input logic [5:0] st, input bit b,
                       input logic [AW-1:0] tgt, input logic [1:0] op,
                       input logic [AW-1:0] addr, input logic [DW-1:0] data);
      obs_t e;
      @(posedge clk);
      #1;
      rst = r; flush = f; stall = st; branch_flag_i = b;
      branch_target_address_i = tgt; rom_op_i = op;
      rom_rw_addr_i = addr; rom_wr_data_i = data;
      if (m_known) begin
         e = '0;
         if (m_ce) begin
            e.ce = 1'b1;
            if (SHARE && op == 2'b10) begin
               e.addr = addr; e.op = 1'b1; e.wdata = data;
            end else if (SHARE && op == 2'b01) begin
               e.addr = addr;
            end else begin
               e.addr = m_pc;
            end
         end
         exp_q.push_back(e);
      end
      if (r) begin
         m_known = 1'b1; m_ce = 1'b0; m_pc = PC_RESET_PC;
      end else if (m_known) begin
         if (!m_ce) begin
            m_ce = 1'b1; m_pc = PC_RESET_PC;
         end else if (f) m_pc = PC_FLUSH_PC;
         else if (st[0]) m_pc = m_pc;
         else if (SHARE && (op == 2'b01 || op == 2'b10)) m_pc = m_pc;
         else if (b) m_pc = tgt;
         else m_pc = m_pc + 32'd4;
      end
   endtask

   task automatic idle(input int n);
      for (int i = 0; i < n; i++) step(0, 0, '0, 0, '0, 2'b00, '0, '0);
   endtask

   task automatic run_to_pc(input logic [AW-1:0] target);
      for (int i = 0; i < 64 && !(m_ce && m_pc == target); i++) idle(1);
   endtask

   initial begin
      // Reset held two cycles, then the start-up sequence.
      step(1, 0, '0, 0, '0, 2'b00, '0, '0);
      step(1, 0, '0, 0, '0, 2'b00, '0, '0);
      idle(6);
      // Reset mid-run at pc 0x10, then restart.
      run_to_pc(32'h10);
      step(1, 0, '0, 0, '0, 2'b00, '0, '0);
      idle(5);
      // Branch to 0 at pc 0x8.
      run_to_pc(32'h8);
      step(0, 0, '0, 1, 32'h0, 2'b00, '0, '0);
      idle(2);
      // One-cycle PC stall at pc 0x8; upper stall bits alone are ignored.
      run_to_pc(32'h8);
      step(0, 0, 6'b000001, 0, '0, 2'b00, '0, '0);
      step(0, 0, 6'b111110, 0, '0, 2'b00, '0, '0);
      idle(2);
      // Shared ROM port: write, read, the unnamed encoding, then fetch resumes.
      step(0, 0, '0, 0, '0, 2'b10, 32'h100, 32'hDEADBEEF);
      step(0, 0, '0, 0, '0, 2'b01, 32'h204, 32'h12345678);
      step(0, 0, '0, 0, '0, 2'b11, 32'h308, 32'hCAFEF00D);
      idle(2);
      // Branch during stall is lost; flush beats stall; PC wraps at the top.
      step(0, 0, 6'b000001, 1, 32'h400, 2'b00, '0, '0);
      step(0, 1, 6'b000001, 1, 32'h500, 2'b10, 32'h44, 32'h55);
      idle(1);
      step(0, 0, '0, 1, 32'hFFFF_FFFC, 2'b00, '0, '0);
      idle(3);

      for (int i = 0; i < 2000; i++) begin
         step(($urandom_range(63) == 0), ($urandom_range(15) == 0),
              {5'($urandom), ($urandom_range(3) == 0)}, ($urandom_range(3) == 0),
              {$urandom_range(32'h3FFF_FFFF), 2'b00}, 2'($urandom_range(3)),
              $urandom, $urandom);
      end

      idle(2);
      @(posedge clk);
      @(posedge clk);
      check("queue_drained", 64'(exp_q.size()), 64'd0);
      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
